alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single `alu` instance between `NUM_REQ` requesters, such as the execute stage and a branch/address helper unit. It accepts one operation at a time over a valid/ready request channel and launches it into the ALU. It captures the registered result and returns it to the granted requester over a valid/ready response channel. It sits between the pipeline clients and the ALU and is the only driver of the ALU's `SrcA`, `SrcB` and `Operation` inputs.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 34 +++
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU opcodes, arbiter FSM state type and opcode legality
//            check used by alu and alu_arbiter.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NE  = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_arb_state_t;

    function automatic logic alu_op_legal(input logic [3:0] op);
        return (op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_EQ, ALU_NE});
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Combinational ALU; unknown operation codes return zero.
// Revision : 1.0  initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    always_comb begin
        ALUResult = '0;
        case (Operation)
            OPCODE_LENGTH'(ALU_AND): ALUResult = SrcA & SrcB;
            OPCODE_LENGTH'(ALU_OR):  ALUResult = SrcA | SrcB;
            // Two's-complement wrap; the same bits serve signed and unsigned.
            OPCODE_LENGTH'(ALU_ADD): ALUResult = SrcA + SrcB;
            OPCODE_LENGTH'(ALU_SUB): ALUResult = SrcA - SrcB;
            OPCODE_LENGTH'(ALU_EQ):  ALUResult = DATA_WIDTH'(SrcA == SrcB);
            OPCODE_LENGTH'(ALU_NE):  ALUResult = DATA_WIDTH'(SrcA != SrcB);
            default:                 ALUResult = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one alu between NUM_REQ requesters.
//            Optional macro ALU_ARB_ILLEGAL_OP_EN flags illegal opcodes.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             rsp_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    alu_arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [DATA_WIDTH-1:0]     srca_q, srca_d;
    logic [DATA_WIDTH-1:0]     srcb_q, srcb_d;
    logic [OPCODE_LENGTH-1:0]  op_q, op_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      grant_found;
    logic [IDX_W-1:0]          grant_idx;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic                      illegal_q, illegal_d;
    logic                      rsp_err_q, rsp_err_d;
`endif

    function automatic logic [IDX_W-1:0] rr_step(input logic [IDX_W-1:0] last, input int step);
        return IDX_W'((int'(last) + step) % NUM_REQ);
    endfunction

    // Walk from the farthest candidate inward so the nearest one after last_grant wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[rr_step(last_grant_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_step(last_grant_q, i);
            end
        end
    end

    // Gated by reset so no accept is advertised while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (reset && state_q == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        illegal_d    = illegal_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    srca_d       = req_srca[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    srcb_d       = req_srcb[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    op_d         = req_op[int'(grant_idx)*OPCODE_LENGTH +: OPCODE_LENGTH];
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_EXEC;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    illegal_d    = !alu_op_legal(4'(req_op[int'(grant_idx)*OPCODE_LENGTH +: OPCODE_LENGTH]));
`endif
                end
            end
            ST_EXEC: begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_data_d = illegal_q ? '0 : alu_result;
                rsp_err_d  = illegal_q;
`else
                rsp_data_d = alu_result;
`endif
                rsp_valid_d           = '0;
                rsp_valid_d[owner_q]  = 1'b1;
                state_d               = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            srca_q       <= '0;
            srcb_q       <= '0;
            op_q         <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            illegal_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            illegal_q    <= illegal_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .SrcA      (srca_q),
        .SrcB      (srcb_q),
        .Operation (op_q),
        .ALUResult (alu_result)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed bench for alu_arbiter: reset, ADD, illegal op,
//            backpressure, round-robin contention and mid-operation reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NR = 2;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam logic EXP_ILL_ERR = 1'b1;
`else
    localparam logic EXP_ILL_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_srca;
    logic [NR*DW-1:0]  req_srcb;
    logic [NR*OW-1:0]  req_op;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (OW),
        .NUM_REQ       (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_srca  (req_srca),
        .req_srcb  (req_srcb),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_srca[i*DW +: DW] = a;
        req_srcb[i*DW +: DW] = b;
        req_op[i*OW +: OW]   = op;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"},  rsp_data,       32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random stimulus
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_srca  = '0;
        req_srcb  = '0;
        req_op    = '0;
        repeat (3) begin
            @(negedge clk);
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            set_req(0, $urandom, $urandom, 4'($urandom));
            set_req(1, $urandom, $urandom, 4'($urandom));
        end
        req_valid = 2'b11;
        #1;
        check_idle_outs("in_reset");

        @(negedge clk);
        req_valid = '0;
        rsp_ready = 2'b11;
        reset     = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 32'(req_ready), 32'h0);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);

        // Single ADD 5 + (-3)
        set_req(0, 32'd5, 32'hFFFF_FFFD, 4'b0010);
        req_valid = 2'b01;
        #1;
        check("add_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        check("add_exec_ready", 32'(req_ready), 32'h0);
        check("add_exec_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("add_rsp_valid", 32'(rsp_valid), 32'h1);
        check("add_rsp_data",  rsp_data,       32'h2);
        check("add_rsp_err",   32'(rsp_err),   32'h0);
        @(negedge clk);
        check("add_done_valid", 32'(rsp_valid), 32'h0);

        // Illegal opcode from requester 0
        set_req(0, 32'd3, 32'd5, 4'b1111);
        req_valid = 2'b01;
        #1;
        check("ill_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("ill_rsp_valid", 32'(rsp_valid), 32'h1);
        check("ill_rsp_data",  rsp_data,       32'h0);
        check("ill_rsp_err",   32'(rsp_err),   32'(EXP_ILL_ERR));
        @(negedge clk);

        // Backpressure: requester 1 EQ 7,7 with its rsp_ready low
        set_req(1, 32'd7, 32'd7, 4'b1000);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        check("bp_accept", 32'(req_ready), 32'h2);
        @(negedge clk);
        set_req(0, 32'd1, 32'd1, 4'b0010);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        check("bp_exec_ready", 32'(req_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", c), 32'(rsp_valid), 32'h2);
            check($sformatf("bp_hold%0d_data", c),  rsp_data,       32'h1);
            check($sformatf("bp_hold%0d_ready", c), 32'(req_ready), 32'h0);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_done_valid", 32'(rsp_valid), 32'h0);

        // Contention: 1+1 from req0, 10-4 from req1, alternate grants
        set_req(1, 32'd10, 32'd4, 4'b0001);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr%0d_grant", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk);
            check($sformatf("rr%0d_exec", k), 32'(req_ready), 32'h0);
            @(negedge clk);
            check($sformatf("rr%0d_valid", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr%0d_data", k),  rsp_data,       (k % 2 == 0) ? 32'd2 : 32'd6);
            @(negedge clk);
        end

        // Reset during EXEC of a SUB from req0
        set_req(0, 32'd9, 32'd4, 4'b0001);
        req_valid = 2'b01;
        #1;
        check("mid_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b0;
        #1;
        check_idle_outs("mid_reset");
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("mid_hold_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_valid", 32'(rsp_valid), 32'h0);
        check("mid_rel_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        check("mid_exec_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("mid_rsp_valid", 32'(rsp_valid), 32'h1);
        check("mid_rsp_data",  rsp_data,       32'd5);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
